simmem_wresp_delay_scheduler: RTL and testbench

Schedules write-response release for the simulated memory. Each accepted write-address request gets a programmable delay. When the delay expires, the scheduler grants one release credit for that AXI ID to the write-response bank. The bank releases responses in order per ID, so this block only counts credits per ID. It also enforces a global outstanding limit so that bank capacity is never exceeded.

---
 rtl/simmem_wresp_delay_scheduler.sv | 124 ++++++++++++
 tb/tb_simmem_wresp_delay_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_wresp_delay_scheduler.sv
// rtl/simmem_wresp_delay_scheduler.sv - per-ID write-response release credit scheduler
// Each accepted write address waits its programmed delay in a slot, then becomes a release credit for its ID.
module simmem_wresp_delay_scheduler #(
  parameter int NumSlots   = 8,
  parameter int IDWidth    = 4,
  parameter int DelayWidth = 6,
  parameter int CntWidth   = $clog2(NumSlots + 1),
  localparam int NumIds    = 2 ** IDWidth
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  waddr_valid_i,
  output logic                  waddr_ready_o,
  input  logic [IDWidth-1:0]    waddr_id_i,
  input  logic [DelayWidth-1:0] delay_i,
  output logic [NumIds-1:0]     release_en_o,
  input  logic [NumIds-1:0]     release_ack_i,
  output logic [CntWidth-1:0]   outstanding_o
);
  localparam int SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  logic [NumSlots-1:0]   r_slot_valid;
  logic [IDWidth-1:0]    r_slot_id  [NumSlots];
  logic [DelayWidth-1:0] r_slot_cnt [NumSlots];
  logic [CntWidth-1:0]   r_credit   [NumIds];
  logic [CntWidth-1:0]   r_outstanding;

  logic                  w_accept;
  logic                  w_free_found;
  logic [SlotIdxW-1:0]   w_free_idx;
  logic [NumSlots-1:0]   w_expire;
  logic [CntWidth-1:0]   w_exp_cnt [NumIds];
  logic [NumIds-1:0]     w_ack_ok;
  logic [CntWidth-1:0]   w_ack_cnt;
  logic [CntWidth-1:0]   w_slots_used;
  logic [31:0]           w_credit_sum;

  // Outstanding counts slots plus credits, so capping it also caps every credit counter.
  assign waddr_ready_o = (r_outstanding < CntWidth'(NumSlots));
  assign w_accept      = waddr_valid_i & waddr_ready_o;
  assign outstanding_o = r_outstanding;

  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!r_slot_valid[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = SlotIdxW'(i);
      end
    end
  end

  always_comb begin
    w_expire     = '0;
    w_slots_used = '0;
    for (int i = 0; i < NumSlots; i++) begin
      w_expire[i]  = r_slot_valid[i] && (r_slot_cnt[i] == '0);
      w_slots_used = w_slots_used + CntWidth'(r_slot_valid[i]);
    end
    for (int k = 0; k < NumIds; k++) begin
      w_exp_cnt[k] = '0;
      for (int i = 0; i < NumSlots; i++) begin
        if (w_expire[i] && (r_slot_id[i] == IDWidth'(k))) begin
          w_exp_cnt[k] = w_exp_cnt[k] + CntWidth'(1);
        end
      end
    end
  end

  always_comb begin
    w_ack_ok     = '0;
    release_en_o = '0;
    w_ack_cnt    = '0;
    w_credit_sum = '0;
    for (int k = 0; k < NumIds; k++) begin
      release_en_o[k] = (r_credit[k] != '0);
      w_ack_ok[k]     = release_ack_i[k] && (r_credit[k] != '0);
      w_ack_cnt       = w_ack_cnt + CntWidth'(w_ack_ok[k]);
      w_credit_sum    = w_credit_sum + 32'(r_credit[k]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_slot_valid  <= '0;
      r_outstanding <= '0;
      for (int i = 0; i < NumSlots; i++) begin
        r_slot_id[i]  <= '0;
        r_slot_cnt[i] <= '0;
      end
      for (int k = 0; k < NumIds; k++) begin
        r_credit[k] <= '0;
      end
    end else begin
      r_outstanding <= r_outstanding + CntWidth'(w_accept) - w_ack_cnt;
      for (int i = 0; i < NumSlots; i++) begin
        if (r_slot_valid[i]) begin
          if (w_expire[i]) begin
            r_slot_valid[i] <= 1'b0;
          end else begin
            r_slot_cnt[i] <= r_slot_cnt[i] - DelayWidth'(1);
          end
        end
        if (w_accept && (w_free_idx == SlotIdxW'(i))) begin
          r_slot_valid[i] <= 1'b1;
          r_slot_id[i]    <= waddr_id_i;
          r_slot_cnt[i]   <= delay_i;
        end
      end
      for (int k = 0; k < NumIds; k++) begin
        r_credit[k] <= r_credit[k] + w_exp_cnt[k] - CntWidth'(w_ack_ok[k]);
      end
    end
  end

  a_accept_has_room: assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_accept |-> (waddr_ready_o && w_free_found));
  a_credit_balance: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_credit_sum + 32'(w_slots_used)) == 32'(r_outstanding));
  a_ack_with_credit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (release_ack_i & ~release_en_o) == '0);

endmodule

// File: tb/tb_simmem_wresp_delay_scheduler.sv
// tb/tb_simmem_wresp_delay_scheduler.sv - bench for simmem_wresp_delay_scheduler
// Directed vector table, hand sequences and random traffic against a release-time reference model.
module tb_simmem_wresp_delay_scheduler;
  localparam int NSLOT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        waddr_valid;
  logic        waddr_ready;
  logic [3:0]  waddr_id;
  logic [5:0]  delay;
  logic [15:0] release_en;
  logic [15:0] release_ack;
  logic [3:0]  outstanding;

  simmem_wresp_delay_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .waddr_valid_i (waddr_valid),
    .waddr_ready_o (waddr_ready),
    .waddr_id_i    (waddr_id),
    .delay_i       (delay),
    .release_en_o  (release_en),
    .release_ack_i (release_ack),
    .outstanding_o (outstanding)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each pending request is just its ID and the absolute edge at which it turns into a credit.
  typedef struct {int id; int rel;} pend_t;
  pend_t pq[$];
  int    credit[16];
  int    cyc = 0;

  typedef struct {
    logic        v;
    logic [3:0]  id;
    logic [5:0]  d;
    logic [15:0] ack;
    logic [15:0] en;
    logic [3:0]  out;
  } vec_t;
  vec_t tbl[26];

  function automatic vec_t mk(input logic v, input logic [3:0] id, input logic [5:0] d,
                              input logic [15:0] ack, input logic [15:0] en, input logic [3:0] out);
    vec_t r;
    r.v = v; r.id = id; r.d = d; r.ack = ack; r.en = en; r.out = out;
    return r;
  endfunction

  function automatic int m_out();
    int s = pq.size();
    for (int k = 0; k < 16; k++) s += credit[k];
    return s;
  endfunction

  function automatic logic [15:0] m_en();
    logic [15:0] e = '0;
    for (int k = 0; k < 16; k++) e[k] = (credit[k] != 0);
    return e;
  endfunction

  function automatic logic [15:0] m_ack_all();
    logic [15:0] a = '0;
    for (int k = 0; k < 16; k++) a[k] = (credit[k] != 0);
    return a;
  endfunction

  task automatic model_reset();
    pq.delete();
    for (int k = 0; k < 16; k++) credit[k] = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, compare all outputs #1 after it.
  task automatic cycle(input logic v, input logic [3:0] id, input logic [5:0] d, input logic [15:0] ack);
    bit acc;
    waddr_valid = v;
    waddr_id    = id;
    delay       = d;
    release_ack = ack;
    acc = v && (m_out() < NSLOT);
    @(posedge clk);
    for (int k = 0; k < 16; k++) if (ack[k] && credit[k] > 0) credit[k]--;
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].rel == cyc) begin
        credit[pq[i].id]++;
        pq.delete(i);
      end
    end
    if (acc) pq.push_back('{int'(id), cyc + int'(d) + 1});
    cyc++;
    #1;
    waddr_valid = 1'b0;
    release_ack = '0;
    check("release_en", release_en, m_en());
    check("outstanding", 32'(outstanding), m_out());
    check("ready", 32'(waddr_ready), 32'(m_out() < NSLOT));
  endtask

  initial begin
    int guard;
    logic [3:0] rid;
    logic [5:0] rd;
    logic [15:0] rack;

    model_reset();
    rst_n = 1'b0; waddr_valid = 1'b1; waddr_id = 4'd3; delay = 6'd0; release_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_en", release_en, 16'h0);
    check("reset_out", 32'(outstanding), 0);
    check("reset_ready", 32'(waddr_ready), 1);
    waddr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl[0] = mk(1, 3, 5, 16'h0, 16'h0, 1);
    for (int i = 1; i <= 5; i++) tbl[i] = mk(0, 0, 0, 16'h0, 16'h0, 1);
    tbl[6]  = mk(0, 0, 0, 16'h0,    16'h0008, 1);
    tbl[7]  = mk(0, 0, 0, 16'h0008, 16'h0,    0);
    tbl[8]  = mk(1, 1, 0, 16'h0,    16'h0,    1);
    tbl[9]  = mk(0, 0, 0, 16'h0,    16'h0002, 1);
    tbl[10] = mk(0, 0, 0, 16'h0,    16'h0002, 1);
    tbl[11] = mk(0, 0, 0, 16'h0002, 16'h0,    0);
    tbl[12] = mk(1, 2, 4, 16'h0,    16'h0,    1);
    tbl[13] = mk(1, 2, 2, 16'h0,    16'h0,    2);
    tbl[14] = mk(1, 2, 2, 16'h0,    16'h0,    3);
    tbl[15] = mk(0, 0, 0, 16'h0,    16'h0,    3);
    tbl[16] = mk(0, 0, 0, 16'h0,    16'h0004, 3);
    tbl[17] = mk(0, 0, 0, 16'h0,    16'h0004, 3);
    tbl[18] = mk(0, 0, 0, 16'h0004, 16'h0004, 2);
    tbl[19] = mk(0, 0, 0, 16'h0004, 16'h0004, 1);
    tbl[20] = mk(0, 0, 0, 16'h0004, 16'h0,    0);
    tbl[21] = mk(1, 4, 0, 16'h0,    16'h0,    1);
    tbl[22] = mk(0, 0, 0, 16'h0,    16'h0010, 1);
    tbl[23] = mk(1, 4, 0, 16'h0,    16'h0010, 2);
    tbl[24] = mk(0, 0, 0, 16'h0010, 16'h0010, 1);
    tbl[25] = mk(0, 0, 0, 16'h0010, 16'h0,    0);
    for (int i = 0; i < 26; i++) begin
      cycle(tbl[i].v, tbl[i].id, tbl[i].d, tbl[i].ack);
      check($sformatf("tbl[%0d].en", i), release_en, tbl[i].en);
      check($sformatf("tbl[%0d].out", i), 32'(outstanding), 32'(tbl[i].out));
    end

    // Fill all slots, then hold a ninth request until a credit is acknowledged.
    for (int i = 0; i < 8; i++) cycle(1, 4'd5, 6'd63, 16'h0);
    check("full_ready", 32'(waddr_ready), 0);
    check("full_out", 32'(outstanding), 8);
    guard = 0;
    while (credit[5] == 0 && guard < 100) begin
      cycle(1, 4'd6, 6'd0, 16'h0);
      guard++;
    end
    if (guard >= 100) begin
      n_vec++; n_err++;
      $display("FAIL full_wait: credit for id 5 not seen within %0d cycles", guard);
    end
    check("ack_cycle_ready", 32'(waddr_ready), 0);
    cycle(1, 4'd6, 6'd0, 16'h0020);
    check("after_ack_ready", 32'(waddr_ready), 1);
    check("after_ack_out", 32'(outstanding), 7);
    cycle(1, 4'd6, 6'd0, 16'h0);
    check("ninth_accept_out", 32'(outstanding), 8);
    guard = 0;
    while (m_out() != 0 && guard < 200) begin
      cycle(0, 4'd0, 6'd0, m_ack_all());
      guard++;
    end
    check("drain_out", 32'(outstanding), 0);

    // Asynchronous reset with slots and credits pending.
    cycle(1, 4'd7, 6'd0, 16'h0);
    cycle(1, 4'd7, 6'd0, 16'h0);
    for (int i = 0; i < 5; i++) cycle(1, 4'd9, 6'd20, 16'h0);
    check("pre_reset_out", 32'(outstanding), 7);
    check("pre_reset_en", release_en, 16'h0080);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_en", release_en, 16'h0);
    check("async_reset_out", 32'(outstanding), 0);
    check("async_reset_ready", 32'(waddr_ready), 1);
    model_reset();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle(1, 4'd0, 6'd1, 16'h0);
    check("post_reset_e0", 32'(release_en[0]), 0);
    cycle(0, 4'd0, 6'd0, 16'h0);
    check("post_reset_e1", 32'(release_en[0]), 0);
    cycle(0, 4'd0, 6'd0, 16'h0);
    check("post_reset_e2", 32'(release_en[0]), 1);
    cycle(0, 4'd0, 6'd0, 16'h0001);
    check("post_reset_drain", 32'(outstanding), 0);

    for (int n = 0; n < 1500; n++) begin
      rid  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      rd   = 6'($urandom_range(0, 9));
      rack = '0;
      for (int k = 0; k < 16; k++) rack[k] = (credit[k] > 0) && ($urandom_range(0, 2) == 0);
      cycle($urandom_range(0, 3) != 0, rid, rd, rack);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
